sram_rr_arbiter: RTL and testbench

- Shares one single_port_sram instance among NUM_REQ requesters: at most one read or write reaches the SRAM per cycle.
- Uses round-robin arbitration with optional locked bursts, so one requester can own the port for up to MAX_BURST consecutive beats.
- Routes each read result back to the requester that issued it, one cycle after the grant.
- Sits between generated pipeline stages and a shared SRAM bank.

---
 rtl/sram_rr_arbiter_if.sv | 27 ++
 rtl/sram_rr_arbiter.sv | 116 +++++++++++
 tb/tb_sram_rr_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_rr_arbiter_if.sv
// Requester-side bundle for the shared SRAM arbiter.
// Masters drive requests; the arbiter answers with grants and read returns.
interface sram_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int AW      = 5
) ();
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       we;
  logic [NUM_REQ-1:0]       lock;
  logic [NUM_REQ*AW-1:0]    addr;
  logic [NUM_REQ*WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       rvalid;
  logic [WIDTH-1:0]         rdata;
  logic                     burst_active;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata, burst_active
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata, burst_active
  );
endinterface

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NUM_REQ requesters.
// Supports locked bursts of up to MAX_BURST beats; reads return one cycle later.
module sram_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 32,
  parameter int MAX_BURST = 4,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  sram_rr_arbiter_if.slave bus,
  output logic [AW-1:0]    sram_addr,
  output logic             sram_ren,
  output logic             sram_wen,
  output logic [WIDTH-1:0] sram_d,
  input  logic [WIDTH-1:0] sram_q
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    UNLOCKED,
    LOCKED
  } mode_t;

  mode_t              mode_q, mode_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [BW-1:0]      beats_q, beats_d;
  logic [NUM_REQ-1:0] rd_pend_q;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      sel;
  logic               hit;

  // State register: pointer, lock mode, owner, beat count, pending reads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q    <= UNLOCKED;
      ptr_q     <= '0;
      owner_q   <= '0;
      beats_q   <= '0;
      rd_pend_q <= '0;
    end else begin
      mode_q    <= mode_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      beats_q   <= beats_d;
      rd_pend_q <= gnt & ~bus.we;
    end
  end

  // Grant selection and next-state: locked owner first, else round-robin.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    sel     = '0;
    hit     = 1'b0;
    mode_d  = mode_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    beats_d = beats_q;
    if (!rst) begin
      hit = 1'b0;
    end else if (mode_q == LOCKED && bus.req[owner_q]) begin
      hit          = 1'b1;
      sel          = owner_q;
      gnt[owner_q] = 1'b1;
      beats_d      = beats_q + BW'(1);
      if (!bus.lock[owner_q] ||
          (int'(beats_q) + 1 == MAX_BURST))
        mode_d = UNLOCKED;
    end else begin
      // An absent owner releases the lock without a bubble.
      mode_d = UNLOCKED;
      for (int j = 0; j < NUM_REQ; j++) begin
        idx = (int'(ptr_q) + j) % NUM_REQ;
        if (!hit && bus.req[idx]) begin
          hit = 1'b1;
          sel = IW'(idx);
        end
      end
      if (hit) begin
        gnt[sel] = 1'b1;
        ptr_d    = IW'((int'(sel) + 1) % NUM_REQ);
        if (bus.lock[sel] && MAX_BURST > 1) begin
          mode_d  = LOCKED;
          owner_d = sel;
          beats_d = BW'(1);
        end
      end
    end
  end

  // SRAM drive from the granted requester; idle bus when nothing granted.
  always_comb begin
    sram_addr = '0;
    sram_d    = '0;
    sram_ren  = 1'b0;
    sram_wen  = 1'b0;
    if (hit) begin
      sram_addr = bus.addr[sel*AW +: AW];
      sram_d    = bus.wdata[sel*WIDTH +: WIDTH];
      sram_wen  = bus.we[sel];
      sram_ren  = !bus.we[sel];
    end
  end

  assign bus.gnt          = gnt;
  assign bus.rvalid       = rd_pend_q;
  assign bus.rdata        = sram_q;
  assign bus.burst_active = (mode_q == LOCKED);

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Self-checking bench for sram_rr_arbiter.
// Per-cycle expected read returns are queued and compared one cycle later.
module tb_sram_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;

  typedef struct {
    logic [N-1:0] mask;
    logic [W-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          fill;
  logic [AW-1:0] sram_addr;
  logic          sram_ren;
  logic          sram_wen;
  logic [W-1:0]  sram_d;
  logic [W-1:0]  sram_q;
  logic [W-1:0]  smem [D];
  logic [W-1:0]  model [D];
  exp_t          sb [$];
  int            vectors = 0;
  int            fails   = 0;
  string         tname;

  sram_rr_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .AW(AW)) bus ();

  sram_rr_arbiter #(
    .NUM_REQ(N), .WIDTH(W), .DEPTH(D), .MAX_BURST(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .sram_addr(sram_addr),
    .sram_ren(sram_ren),
    .sram_wen(sram_wen),
    .sram_d(sram_d),
    .sram_q(sram_q)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pat(input int a);
    return 32'hA5A5_0000 | W'(a * 17);
  endfunction

  // Stand-in single-port SRAM with registered read.
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < D; i++) smem[i] <= pat(i);
    end else begin
      if (sram_wen) smem[sram_addr] <= sram_d;
      if (sram_ren) sram_q <= smem[sram_addr];
    end
  end

  task automatic set_req(input int i, input logic w,
                         input logic [AW-1:0] a,
                         input logic [W-1:0] d);
    bus.we[i]           = w;
    bus.addr[i*AW +: AW] = a;
    bus.wdata[i*W +: W] = d;
  endtask

  task automatic tick(input logic [N-1:0] eg, input logic eba);
    exp_t          e;
    int            k;
    logic [AW-1:0] a;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (bus.rvalid !== e.mask) begin
        fails++;
        $display("FAIL %s rvalid got %b exp %b", tname, bus.rvalid, e.mask);
      end
      if (e.mask != '0) begin
        vectors++;
        if (bus.rdata !== e.data) begin
          fails++;
          $display("FAIL %s rdata got %h exp %h", tname, bus.rdata, e.data);
        end
      end
    end
    vectors++;
    if (bus.gnt !== eg) begin
      fails++;
      $display("FAIL %s gnt got %b exp %b", tname, bus.gnt, eg);
    end
    vectors++;
    if (bus.burst_active !== eba) begin
      fails++;
      $display("FAIL %s burst_active got %b exp %b", tname, bus.burst_active, eba);
    end
    e.mask = '0;
    e.data = '0;
    if (eg != '0) begin
      k = 0;
      for (int i = 0; i < N; i++) if (eg[i]) k = i;
      a = bus.addr[k*AW +: AW];
      vectors++;
      if (sram_addr !== a || sram_wen !== bus.we[k] ||
          sram_ren !== !bus.we[k]) begin
        fails++;
        $display("FAIL %s sram got a=%h r=%b w=%b exp a=%h w=%b",
                 tname, sram_addr, sram_ren, sram_wen, a, bus.we[k]);
      end
      if (bus.we[k]) begin
        model[a] = bus.wdata[k*W +: W];
        vectors++;
        if (sram_d !== model[a]) begin
          fails++;
          $display("FAIL %s sram_d got %h exp %h", tname, sram_d, model[a]);
        end
      end else begin
        e.mask = eg;
        e.data = model[a];
      end
    end else begin
      vectors++;
      if (sram_ren !== 1'b0 || sram_wen !== 1'b0) begin
        fails++;
        $display("FAIL %s sram idle got r=%b w=%b exp 0 0",
                 tname, sram_ren, sram_wen);
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req  = '0;
    bus.we   = '0;
    bus.lock = '0;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i + 1), '0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick('0, 1'b0);
    tick('0, 1'b0);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    tname = "reset";
    bus.req = 4'b1111;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick('0, 1'b0);
    rst = 1'b1;
    tick(4'b0001, 1'b0);
    idle_inputs();
    tick('0, 1'b0);
  endtask

  task automatic test_round_robin();
    tname = "round_robin";
    do_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < 8; i++) tick(N'(1 << (i % 4)), 1'b0);
    tname = "idle_hold";
    bus.req = '0;
    tick('0, 1'b0);
    tick('0, 1'b0);
    bus.req = 4'b1111;
    tick(4'b0001, 1'b0);
    tick(4'b0010, 1'b0);
    idle_inputs();
    tick('0, 1'b0);
  endtask

  task automatic test_read_after_write();
    tname = "raw";
    do_reset();
    set_req(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
    bus.req = 4'b0010;
    tick(4'b0010, 1'b0);
    set_req(1, 1'b0, 5'd1, '0);
    set_req(2, 1'b0, 5'd5, '0);
    bus.req = 4'b0100;
    tick(4'b0100, 1'b0);
    idle_inputs();
    tick('0, 1'b0);
    tick('0, 1'b0);
  endtask

  task automatic test_max_burst();
    tname = "max_burst";
    do_reset();
    set_req(0, 1'b0, 5'd9, '0);
    set_req(1, 1'b0, 5'd10, '0);
    bus.req  = 4'b0011;
    bus.lock = 4'b0001;
    tick(4'b0001, 1'b0);
    tick(4'b0001, 1'b1);
    tick(4'b0001, 1'b1);
    tick(4'b0001, 1'b1);
    tick(4'b0010, 1'b0);
    idle_inputs();
    tick('0, 1'b0);
  endtask

  task automatic test_early_release();
    tname = "early_release";
    do_reset();
    bus.req  = 4'b0011;
    bus.lock = 4'b0001;
    tick(4'b0001, 1'b0);
    bus.lock = 4'b0000;
    tick(4'b0001, 1'b1);
    tick(4'b0010, 1'b0);
    idle_inputs();
    tick('0, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    tname = "reset_mid_burst";
    do_reset();
    bus.req  = 4'b0011;
    bus.lock = 4'b0001;
    tick(4'b0001, 1'b0);
    rst = 1'b0;
    tick('0, 1'b1);
    rst = 1'b1;
    bus.lock = 4'b0000;
    tick(4'b0001, 1'b0);
    tick(4'b0010, 1'b0);
    idle_inputs();
    tick('0, 1'b0);
  endtask

  initial begin
    rst  = 1'b0;
    fill = 1'b1;
    idle_inputs();
    for (int i = 0; i < D; i++) model[i] = pat(i);
    @(posedge clk);
    #1;
    fill = 1'b0;
    test_reset();
    test_round_robin();
    test_read_after_write();
    test_max_burst();
    test_early_release();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
